// File: rtl/tdp_ram_init.sv
// True dual-port synchronous RAM with a clear sequencer, selectable same-port
// read-during-write, write-collision priority and an optional output register.
module tdp_ram_init #(
  parameter int unsigned       length        = 8,
  parameter int unsigned       location      = 16,
  parameter int unsigned       RDW_MODE      = 0,
  parameter int unsigned       COLLISION_PRI = 0,
  parameter int unsigned       OUT_REG       = 0,
  parameter logic [length-1:0] INIT_VAL      = '0,
  localparam int unsigned      AW            = $clog2(location)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              a_en,
  input  logic              a_we,
  input  logic [AW-1:0]     a_addr,
  input  logic [length-1:0] a_wdata,
  input  logic              b_en,
  input  logic              b_we,
  input  logic [AW-1:0]     b_addr,
  input  logic [length-1:0] b_wdata,
  output logic [length-1:0] a_rdata,
  output logic              a_rvalid,
  output logic [length-1:0] b_rdata,
  output logic              b_rvalid,
  output logic              init_busy,
  output logic              collision
);

  typedef enum logic {INIT, IDLE} state_t;

  state_t              state;
  logic [AW-1:0]       cnt;
  logic [length-1:0]   mem [location];

  logic                idle, a_acc, b_acc, a_in, b_in, a_wr, b_wr;
  logic                coll_c, a_wr_ok, b_wr_ok;
  logic [length-1:0]   win_data, a_old, b_old, a_new, b_new, a_rd, b_rd;
  logic [length-1:0]   a_rd1, b_rd1;
  logic                a_rv1, b_rv1;

  assign idle  = (state == IDLE);
  assign a_acc = idle & a_en;
  assign b_acc = idle & b_en;
  assign a_in  = 32'(a_addr) < location;
  assign b_in  = 32'(b_addr) < location;
  assign a_wr  = a_acc & a_we & a_in;
  assign b_wr  = b_acc & b_we & b_in;

  // Same-address double write: only the priority port reaches the array.
  assign coll_c   = a_wr & b_wr & (a_addr == b_addr);
  assign a_wr_ok  = a_wr & ~(coll_c & (COLLISION_PRI == 1));
  assign b_wr_ok  = b_wr & ~(coll_c & (COLLISION_PRI == 0));
  assign win_data = (COLLISION_PRI == 0) ? a_wdata : b_wdata;

  assign a_old = a_in ? mem[a_addr] : '0;
  assign b_old = b_in ? mem[b_addr] : '0;
  assign a_new = coll_c ? win_data : a_wdata;
  assign b_new = coll_c ? win_data : b_wdata;
  assign a_rd  = ((RDW_MODE == 1) && a_wr) ? a_new : a_old;
  assign b_rd  = ((RDW_MODE == 1) && b_wr) ? b_new : b_old;

  // Array: the sequencer owns it in INIT, the ports own it in IDLE.
  always_ff @(posedge clk) begin
    if (!idle) begin
      mem[cnt] <= INIT_VAL;
    end else if (rst_n) begin
      if (a_wr_ok) mem[a_addr] <= a_wdata;
      if (b_wr_ok) mem[b_addr] <= b_wdata;
    end
  end

  // Sequencer FSM, first read stage and collision strobe.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= INIT;
      cnt       <= '0;
      init_busy <= 1'b1;
      collision <= 1'b0;
      a_rd1     <= '0;
      b_rd1     <= '0;
      a_rv1     <= 1'b0;
      b_rv1     <= 1'b0;
    end else begin
      collision <= coll_c;
      a_rv1     <= a_acc;
      b_rv1     <= b_acc;
      if (a_acc) a_rd1 <= a_rd;
      if (b_acc) b_rd1 <= b_rd;
      case (state)
        INIT: begin
          if (cnt == AW'(location - 1)) begin
            state     <= IDLE;
            init_busy <= 1'b0;
            cnt       <= '0;
          end else begin
            cnt <= cnt + AW'(1);
          end
        end
        IDLE: begin
          if (clr) begin
            state     <= INIT;
            init_busy <= 1'b1;
            cnt       <= '0;
          end
        end
        default: begin
          state     <= INIT;
          init_busy <= 1'b1;
          cnt       <= '0;
        end
      endcase
    end
  end

  if (OUT_REG != 0) begin : g_oreg
    // Second stage: rvalid travels with rdata, rdata holds between accesses.
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        a_rdata  <= '0;
        b_rdata  <= '0;
        a_rvalid <= 1'b0;
        b_rvalid <= 1'b0;
      end else begin
        a_rvalid <= a_rv1;
        b_rvalid <= b_rv1;
        if (a_rv1) a_rdata <= a_rd1;
        if (b_rv1) b_rdata <= b_rd1;
      end
    end
  end else begin : g_noreg
    assign a_rdata  = a_rd1;
    assign b_rdata  = b_rd1;
    assign a_rvalid = a_rv1;
    assign b_rvalid = b_rv1;
  end

endmodule
